fix_rx_framer: RTL and testbench

FIX_RX_FRAMER -- requirements
Module: fix_rx_framer

---
 rtl/fix_rx_framer.sv | 207 ++++++++++++++++++++
 tb/tb_fix_rx_framer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fix_rx_framer.sv
// FIX-style tag=value framer for a TOE byte stream: splits fields, streams value
// bytes tagged with their field, verifies the tag-10 checksum and closes or aborts messages.
module fix_rx_framer #(
  parameter int         NUM_HOSTS      = 4,
  parameter int         HOST_W         = 2,
  parameter logic [7:0] DELIM          = 8'h3B,
  parameter int         TAG_W          = 16,
  parameter int         MAX_TAG_DIGITS = 5,
  parameter int         MAX_VAL_LEN    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [7:0]        message_i,
  input  logic              sof_i,
  input  logic [HOST_W-1:0] host_i,
  output logic              value_valid_o,
  output logic [7:0]        value_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic              field_end_o,
  output logic [HOST_W-1:0] host_o,
  output logic              msg_done_o,
  output logic              msg_err_o,
  output logic [2:0]        err_code_o,
  output logic [15:0]       ok_cnt_o,
  output logic [15:0]       err_cnt_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_TAG     = 2'd1;
  localparam logic [1:0] S_VALUE   = 2'd2;
  localparam logic [1:0] S_DISCARD = 2'd3;

  localparam logic [2:0] E_NONE    = 3'd0;
  localparam logic [2:0] E_BADTAG  = 3'd1;
  localparam logic [2:0] E_NOBEGIN = 3'd2;
  localparam logic [2:0] E_OVERLEN = 3'd3;
  localparam logic [2:0] E_CKSUM   = 3'd4;
  localparam logic [2:0] E_TRUNC   = 3'd5;
  localparam logic [2:0] E_EMPTY   = 3'd6;

  localparam int TL_W = $clog2(MAX_TAG_DIGITS + 1);
  localparam int VL_W = $clog2(MAX_VAL_LEN + 1);
  localparam logic [TL_W-1:0]  TL_MAX    = TL_W'(MAX_TAG_DIGITS);
  localparam logic [VL_W-1:0]  VL_MAX    = VL_W'(MAX_VAL_LEN);
  localparam logic [TAG_W-1:0] TAG_BEGIN = TAG_W'(8);
  localparam logic [TAG_W-1:0] TAG_CKSUM = TAG_W'(10);

  if (HOST_W != $clog2(NUM_HOSTS)) begin : g_host_w_check
    $error("HOST_W must equal clog2(NUM_HOSTS)");
  end

  logic [1:0]       state;
  logic [TAG_W-1:0] tag;
  logic [TL_W-1:0]  tag_len;
  logic [VL_W-1:0]  val_len;
  logic [7:0]       sum;
  logic [7:0]       ref_sum;
  logic             first_field;
  logic [9:0]       ck_val;
  logic [1:0]       ck_len;
  logic             ck_bad;

  logic             is_digit;
  logic             is_eq;
  logic             is_delim;
  logic [3:0]       digit;
  logic [TAG_W-1:0] tag_acc;
  logic             ck_ok;
  logic [2:0]       err_next;

  assign is_digit = (message_i >= 8'h30) && (message_i <= 8'h39);
  assign is_eq    = (message_i == 8'h3D);
  assign is_delim = (message_i == DELIM);
  assign digit    = message_i[3:0];
  assign tag_acc  = tag * TAG_W'(10) + TAG_W'(digit);
  // The tag-10 value must be exactly three digits spelling the sum captured at field start.
  assign ck_ok    = !ck_bad && (ck_len == 2'd3) && (ck_val == {2'b00, ref_sum});

  always_comb begin
    err_next = E_NONE;
    if (valid_i) begin
      if (sof_i) begin
        if (state == S_TAG || state == S_VALUE) err_next = E_TRUNC;
        else if (!is_digit)                     err_next = E_BADTAG;
      end else begin
        case (state)
          S_TAG: begin
            if (is_digit) begin
              if (tag_len == TL_MAX) err_next = E_BADTAG;
            end else if (!is_eq || tag_len == '0) begin
              err_next = E_BADTAG;
            end else if (first_field && tag != TAG_BEGIN) begin
              err_next = E_NOBEGIN;
            end
          end
          S_VALUE: begin
            if (is_delim) begin
              if (val_len == '0)                     err_next = E_EMPTY;
              else if (tag_o == TAG_CKSUM && !ck_ok) err_next = E_CKSUM;
            end else if (val_len == VL_MAX) begin
              err_next = E_OVERLEN;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      tag           <= '0;
      tag_len       <= '0;
      val_len       <= '0;
      sum           <= 8'd0;
      ref_sum       <= 8'd0;
      first_field   <= 1'b0;
      ck_val        <= 10'd0;
      ck_len        <= 2'd0;
      ck_bad        <= 1'b0;
      value_valid_o <= 1'b0;
      value_o       <= 8'd0;
      tag_o         <= '0;
      field_end_o   <= 1'b0;
      host_o        <= '0;
      msg_done_o    <= 1'b0;
      msg_err_o     <= 1'b0;
      err_code_o    <= E_NONE;
      ok_cnt_o      <= 16'd0;
      err_cnt_o     <= 16'd0;
    end else begin
      value_valid_o <= 1'b0;
      field_end_o   <= 1'b0;
      msg_done_o    <= 1'b0;
      msg_err_o     <= 1'b0;
      err_code_o    <= E_NONE;
      if (valid_i) begin
        if (err_next != E_NONE) begin
          msg_err_o  <= 1'b1;
          err_code_o <= err_next;
          if (err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
        end
        // A start byte always opens a fresh message, even when it truncates the old one.
        if (sof_i) begin
          host_o      <= host_i;
          sum         <= message_i;
          ref_sum     <= 8'd0;
          first_field <= 1'b1;
          val_len     <= '0;
          tag         <= is_digit ? TAG_W'(digit) : '0;
          tag_len     <= is_digit ? TL_W'(1) : '0;
          state       <= is_digit ? S_TAG : S_DISCARD;
        end else if (err_next != E_NONE) begin
          state <= S_DISCARD;
        end else begin
          case (state)
            S_TAG: begin
              sum <= sum + message_i;
              if (is_digit) begin
                tag     <= tag_acc;
                tag_len <= tag_len + TL_W'(1);
              end else begin
                state   <= S_VALUE;
                tag_o   <= tag;
                val_len <= '0;
                ck_val  <= 10'd0;
                ck_len  <= 2'd0;
                ck_bad  <= 1'b0;
              end
            end
            S_VALUE: begin
              sum <= sum + message_i;
              if (is_delim) begin
                field_end_o <= 1'b1;
                if (tag_o == TAG_CKSUM) begin
                  msg_done_o <= 1'b1;
                  state      <= S_IDLE;
                  if (ok_cnt_o != 16'hFFFF) ok_cnt_o <= ok_cnt_o + 16'd1;
                end else begin
                  state       <= S_TAG;
                  tag         <= '0;
                  tag_len     <= '0;
                  first_field <= 1'b0;
                  ref_sum     <= sum + message_i;
                end
              end else begin
                value_valid_o <= 1'b1;
                value_o       <= message_i;
                val_len       <= val_len + VL_W'(1);
                if (is_digit && ck_len != 2'd3) begin
                  ck_val <= ck_val * 10'd10 + {6'd0, digit};
                  ck_len <= ck_len + 2'd1;
                end else begin
                  ck_bad <= 1'b1;
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_fix_rx_framer.sv
// Bench for fix_rx_framer: directed scenarios plus random messages, each cycle
// compared against a message-level reference model built from byte queues.
module tb_fix_rx_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic [7:0]  message_i = 8'd0;
  logic        sof_i = 1'b0;
  logic [1:0]  host_i = 2'd0;
  logic        value_valid_o;
  logic [7:0]  value_o;
  logic [15:0] tag_o;
  logic        field_end_o;
  logic [1:0]  host_o;
  logic        msg_done_o;
  logic        msg_err_o;
  logic [2:0]  err_code_o;
  logic [15:0] ok_cnt_o;
  logic [15:0] err_cnt_o;

  fix_rx_framer dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .message_i(message_i), .sof_i(sof_i),
    .host_i(host_i), .value_valid_o(value_valid_o), .value_o(value_o), .tag_o(tag_o),
    .field_end_o(field_end_o), .host_o(host_o), .msg_done_o(msg_done_o),
    .msg_err_o(msg_err_o), .err_code_o(err_code_o), .ok_cnt_o(ok_cnt_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the message so far, the pending tag text and the value text.
  byte unsigned msg_q[$];
  byte unsigned tag_txt[$];
  byte unsigned val_q[$];
  byte unsigned stim_q[$];
  bit m_active, m_in_value;
  int m_field_start, m_nfields, m_cur_tag, m_host, m_ok, m_err, m_value;
  bit e_vv, e_fe, e_done, e_err;
  int e_code;

  function automatic bit is_dig(input byte unsigned b);
    return b >= 8'h30 && b <= 8'h39;
  endfunction

  function automatic int tag_value();
    longint t = 0;
    foreach (tag_txt[i]) t = (t * 10 + (tag_txt[i] - 8'h30)) % 65536;
    return int'(t);
  endfunction

  function automatic int ref_checksum();
    int s = 0;
    for (int i = 0; i < m_field_start; i++) s += msg_q[i];
    return s % 256;
  endfunction

  function automatic bit cksum_good();
    if (val_q.size() != 3) return 1'b0;
    foreach (val_q[i]) if (!is_dig(val_q[i])) return 1'b0;
    return ((val_q[0] - 8'h30) * 100 + (val_q[1] - 8'h30) * 10 + (val_q[2] - 8'h30)) == ref_checksum();
  endfunction

  task automatic model_reset();
    msg_q.delete(); tag_txt.delete(); val_q.delete();
    m_active = 0; m_in_value = 0; m_field_start = 0; m_nfields = 0;
    m_cur_tag = 0; m_host = 0; m_ok = 0; m_err = 0; m_value = 0;
    e_vv = 0; e_fe = 0; e_done = 0; e_err = 0; e_code = 0;
  endtask

  task automatic model_step(input bit v, input bit sof, input int h, input byte unsigned b);
    e_vv = 0; e_fe = 0; e_done = 0; e_err = 0; e_code = 0;
    if (!v) return;
    if (sof) begin
      if (m_active) e_code = 5;
      msg_q = {b}; tag_txt.delete(); val_q.delete();
      m_field_start = 0; m_nfields = 0; m_in_value = 0; m_host = h;
      if (is_dig(b)) begin
        m_active = 1; tag_txt.push_back(b);
      end else begin
        m_active = 0;
        if (e_code == 0) e_code = 1;
      end
    end else if (m_active) begin
      msg_q.push_back(b);
      if (!m_in_value) begin
        if (is_dig(b)) begin
          if (tag_txt.size() == 5) e_code = 1;
          else tag_txt.push_back(b);
        end else if (b == 8'h3D) begin
          if (tag_txt.size() == 0) e_code = 1;
          else if (m_nfields == 0 && tag_value() != 8) e_code = 2;
          else begin
            m_in_value = 1; m_cur_tag = tag_value(); val_q.delete();
          end
        end else e_code = 1;
      end else begin
        if (b == 8'h3B) begin
          if (val_q.size() == 0) e_code = 6;
          else if (m_cur_tag == 10) begin
            if (cksum_good()) begin
              e_fe = 1; e_done = 1; m_active = 0;
              if (m_ok < 65535) m_ok++;
            end else e_code = 4;
          end else begin
            e_fe = 1; m_nfields++; tag_txt.delete(); m_in_value = 0;
            m_field_start = msg_q.size();
          end
        end else if (val_q.size() == 64) e_code = 3;
        else begin
          e_vv = 1; m_value = b; val_q.push_back(b);
        end
      end
      if (e_code != 0) m_active = 0;
    end
    if (e_code != 0) begin
      e_err = 1;
      if (m_err < 65535) m_err++;
    end
  endtask

  task automatic send(input bit v, input bit sof, input int h, input byte unsigned b);
    valid_i = v; sof_i = sof; host_i = h[1:0]; message_i = b;
    model_step(v, sof, h, b);
    @(posedge clk); #1;
    check("value_valid", value_valid_o, e_vv);
    if (e_vv) begin
      check("value", value_o, m_value);
      check("value_tag", tag_o, m_cur_tag);
    end
    check("field_end", field_end_o, e_fe);
    if (e_fe) check("field_end_tag", tag_o, m_cur_tag);
    check("msg_done", msg_done_o, e_done);
    check("msg_err", msg_err_o, e_err);
    if (e_err) check("err_code", err_code_o, e_code);
    check("host", host_o, m_host);
    check("ok_cnt", ok_cnt_o, m_ok);
    check("err_cnt", err_cnt_o, m_err);
  endtask

  task automatic send_str(input string s, input bit sof_first, input int h);
    for (int i = 0; i < s.len(); i++) send(1, sof_first && i == 0, h, s[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1; valid_i = 0; sof_i = 0;
    #2;
    model_reset();
    check("rst_value_valid", value_valid_o, 0);
    check("rst_value", value_o, 0);
    check("rst_tag", tag_o, 0);
    check("rst_field_end", field_end_o, 0);
    check("rst_host", host_o, 0);
    check("rst_done", msg_done_o, 0);
    check("rst_err", msg_err_o, 0);
    check("rst_code", err_code_o, 0);
    check("rst_ok_cnt", ok_cnt_o, 0);
    check("rst_err_cnt", err_cnt_o, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_num(input int n);
    byte unsigned d[$];
    do begin d.push_front(byte'(8'h30 + n % 10)); n = n / 10; end while (n > 0);
    foreach (d[i]) stim_q.push_back(d[i]);
  endtask

  task automatic gen_msg();
    int nf, len, s;
    byte unsigned c;
    stim_q.delete();
    nf = $urandom_range(1, 3);
    for (int f = 0; f < nf; f++) begin
      push_num(f == 0 ? 8 : int'($urandom_range(1, 99999)));
      stim_q.push_back(8'h3D);
      len = ($urandom_range(0, 19) == 0) ? int'($urandom_range(63, 65)) : int'($urandom_range(1, 6));
      for (int k = 0; k < len; k++) begin
        do c = byte'($urandom_range(33, 126)); while (c == 8'h3B);
        stim_q.push_back(c);
      end
      stim_q.push_back(8'h3B);
    end
    s = 0;
    foreach (stim_q[i]) s += stim_q[i];
    s = s % 256;
    stim_q.push_back(8'h31); stim_q.push_back(8'h30); stim_q.push_back(8'h3D);
    stim_q.push_back(byte'(8'h30 + s / 100));
    stim_q.push_back(byte'(8'h30 + (s / 10) % 10));
    stim_q.push_back(byte'(8'h30 + s % 10));
    stim_q.push_back(8'h3B);
    if ($urandom_range(0, 5) == 0)
      stim_q[$urandom_range(1, stim_q.size() - 1)] = byte'($urandom_range(32, 126));
  endtask

  initial begin
    int h, cut;
    string s;
    do_reset();

    send_str("8=A;10=241;", 1, 2);
    check("d018_ok_cnt", ok_cnt_o, 1);
    check("d018_host", host_o, 2);

    send_str("8=A;10=240;", 1, 1);
    send_str("8=B;", 0, 3);
    check("d019_err_cnt", err_cnt_o, 1);

    send_str("9=A;", 1, 0);
    send_str("8x=", 1, 3);

    s = "8=";
    for (int i = 0; i < 65; i++) s = {s, "B"};
    send_str({s, ";"}, 1, 1);
    send_str("8=;", 1, 2);

    send_str("8=AB", 1, 1);
    send_str("8=A;10=241;", 1, 3);

    send_str("8=AB", 1, 2);
    do_reset();
    send_str("8=A;10=241;", 1, 1);
    check("d023_ok_cnt", ok_cnt_o, 1);

    for (int m = 0; m < 200; m++) begin
      gen_msg();
      h = $urandom_range(0, 3);
      cut = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, stim_q.size() - 1)) : stim_q.size();
      for (int i = 0; i < cut; i++) begin
        while ($urandom_range(0, 3) == 0)
          send(0, $urandom_range(0, 1), $urandom_range(0, 3), byte'($urandom_range(0, 255)));
        send(1, i == 0, (i == 0) ? h : int'($urandom_range(0, 3)), stim_q[i]);
      end
      if ($urandom_range(0, 39) == 0) do_reset();
      for (int k = $urandom_range(0, 2); k > 0; k--)
        send(1, 0, $urandom_range(0, 3), byte'($urandom_range(0, 255)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
